// File: rtl/reg_xfer_seq_pkg.sv
// Shared state, opcode and register encodings for the register-transfer sequencer.
package reg_xfer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic {
    OP_LOAD = 1'b0,
    OP_MOVE = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    SRC_U5 = 2'b00,
    SRC_U2 = 2'b01,
    SRC_U3 = 2'b10,
    SRC_U4 = 2'b11
  } src_t;

  typedef enum logic [1:0] {
    DST_NONE = 2'b00,
    DST_U2   = 2'b01,
    DST_U3   = 2'b10,
    DST_U4   = 2'b11
  } dst_t;

  typedef enum logic {
    PH_IN  = 1'b0,
    PH_DST = 1'b1
  } phase_t;

  // A zero-length segment still occupies one cycle.
  function automatic int unsigned seg_len(input int unsigned cyc);
    return (cyc == 0) ? 1 : cyc;
  endfunction

endpackage

// File: rtl/reg_xfer_seq_timer.sv
// Setup/strobe/hold segment timer for one load phase; restarted by i_start.
module xfer_phase_timer
  import reg_xfer_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 10,
  parameter int unsigned STROBE_CYC = 10,
  parameter int unsigned HOLD_CYC   = 10
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_start,
  output logic o_setup,
  output logic o_strobe,
  output logic o_hold,
  output logic o_last,
  output logic o_end
);

  localparam int unsigned S    = seg_len(SETUP_CYC);
  localparam int unsigned T    = seg_len(STROBE_CYC);
  localparam int unsigned H    = seg_len(HOLD_CYC);
  localparam int unsigned MAXP = (S > T) ? ((S > H) ? S : H) : ((T > H) ? T : H);
  localparam int unsigned CW   = $clog2(MAXP) + 1;

  state_t          r_stage;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_len_m1;
  logic            w_last;

  // Counter restarts per segment, so it only ever has to reach MAXP-1.
  always_comb begin
    w_len_m1 = '0;
    case (r_stage)
      ST_SETUP:  w_len_m1 = CW'(S - 1);
      ST_STROBE: w_len_m1 = CW'(T - 1);
      ST_HOLD:   w_len_m1 = CW'(H - 1);
      default:   w_len_m1 = '0;
    endcase
  end

  assign w_last   = (r_stage != ST_IDLE) && (r_cnt == w_len_m1);
  assign o_setup  = (r_stage == ST_SETUP);
  assign o_strobe = (r_stage == ST_STROBE);
  assign o_hold   = (r_stage == ST_HOLD);
  assign o_last   = w_last;
  assign o_end    = (r_stage == ST_HOLD) && w_last;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stage <= ST_IDLE;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_stage <= ST_SETUP;
      r_cnt   <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
      case (r_stage)
        ST_SETUP:  r_stage <= ST_STROBE;
        ST_STROBE: r_stage <= ST_HOLD;
        default:   r_stage <= ST_IDLE;
      endcase
    end else if (r_stage != ST_IDLE) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reg_xfer_seq.sv
// Command sequencer driving switch data, bus select and register load strobes.
// Optional same-register MOVE rejection with an err pulse: define REG_XFER_CHK_EN.
module reg_xfer_seq
  import reg_xfer_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 10,
  parameter int unsigned STROBE_CYC = 10,
  parameter int unsigned HOLD_CYC   = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [1:0] cmd_src,
  input  logic [1:0] cmd_dst,
  input  logic [3:0] cmd_data,
  output logic [3:0] sw_data,
  output logic [1:0] bus_sel,
  output logic       in_ld_n,
  output logic       u2_ld_n,
  output logic       u3_ld_n,
  output logic       u4_ld,
  output logic       done
`ifdef REG_XFER_CHK_EN
  ,
  output logic       err
`endif
);

  state_t     r_state;
  phase_t     r_phase;
  dst_t       r_dst;
  logic [3:0] r_sw_data;
  logic [1:0] r_bus_sel;
  logic       r_in_ld_n, r_u2_ld_n, r_u3_ld_n, r_u4_ld;
  logic       r_done, r_ready;
  logic       w_accept, w_reject, w_start;
  logic       w_setup, w_strobe, w_hold, w_last, w_end;

  assign w_accept = cmd_valid && r_ready && (r_state == ST_IDLE);

`ifdef REG_XFER_CHK_EN
  logic r_err;
  assign w_reject = (op_t'(cmd_op) == OP_MOVE) && (dst_t'(cmd_dst) != DST_NONE)
                    && (cmd_src == cmd_dst);
  assign err      = r_err;
`else
  assign w_reject = 1'b0;
`endif

  // The DST phase of a LOAD restarts the timer on the last IN hold cycle.
  assign w_start = (w_accept && !w_reject) || (r_state == ST_HOLD && w_end && r_phase == PH_IN);

  xfer_phase_timer #(
    .SETUP_CYC  (SETUP_CYC),
    .STROBE_CYC (STROBE_CYC),
    .HOLD_CYC   (HOLD_CYC)
  ) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .i_start  (w_start),
    .o_setup  (w_setup),
    .o_strobe (w_strobe),
    .o_hold   (w_hold),
    .o_last   (w_last),
    .o_end    (w_end)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_phase   <= PH_IN;
      r_dst     <= DST_NONE;
      r_sw_data <= '0;
      r_bus_sel <= '0;
      r_in_ld_n <= 1'b1;
      r_u2_ld_n <= 1'b1;
      r_u3_ld_n <= 1'b1;
      r_u4_ld   <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b0;
`ifdef REG_XFER_CHK_EN
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_ready <= 1'b0;
            if (w_reject) begin
              r_state <= ST_DONE;
`ifdef REG_XFER_CHK_EN
              r_err   <= 1'b1;
`endif
            end else begin
              r_state <= ST_SETUP;
              r_dst   <= dst_t'(cmd_dst);
              if (op_t'(cmd_op) == OP_LOAD) begin
                r_phase   <= PH_IN;
                r_sw_data <= cmd_data;
                r_bus_sel <= SRC_U5;
              end else begin
                r_phase   <= PH_DST;
                r_bus_sel <= cmd_src;
              end
            end
          end
        end
        ST_SETUP: begin
          if (w_setup && w_last) begin
            r_state <= ST_STROBE;
            if (r_phase == PH_IN) begin
              r_in_ld_n <= 1'b0;
            end else begin
              case (r_dst)
                DST_U2:  r_u2_ld_n <= 1'b0;
                DST_U3:  r_u3_ld_n <= 1'b0;
                DST_U4:  r_u4_ld   <= 1'b1;
                default: ;
              endcase
            end
          end
        end
        ST_STROBE: begin
          if (w_strobe && w_last) begin
            r_state   <= ST_HOLD;
            r_in_ld_n <= 1'b1;
            r_u2_ld_n <= 1'b1;
            r_u3_ld_n <= 1'b1;
            r_u4_ld   <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (w_hold && w_last) begin
            if (r_phase == PH_IN) begin
              r_phase   <= PH_DST;
              r_bus_sel <= SRC_U5;
              r_state   <= ST_SETUP;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
`ifdef REG_XFER_CHK_EN
          r_err   <= 1'b0;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign sw_data   = r_sw_data;
  assign bus_sel   = r_bus_sel;
  assign in_ld_n   = r_in_ld_n;
  assign u2_ld_n   = r_u2_ld_n;
  assign u3_ld_n   = r_u3_ld_n;
  assign u4_ld     = r_u4_ld;
  assign done      = r_done;

endmodule

// File: tb/tb_reg_xfer_seq.sv
// Scoreboard bench for reg_xfer_seq at the default 10/10/10 phase timing.
module tb_reg_xfer_seq;

  localparam int unsigned SETUP  = 10;
  localparam int unsigned STROBE = 10;
  localparam int unsigned HOLD   = 10;
  localparam int          PH     = SETUP + STROBE + HOLD;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_op = 1'b0;
  logic [1:0] cmd_src = 2'b00;
  logic [1:0] cmd_dst = 2'b00;
  logic [3:0] cmd_data = 4'h0;
  logic       cmd_ready;
  logic [3:0] sw_data;
  logic [1:0] bus_sel;
  logic       in_ld_n, u2_ld_n, u3_ld_n, u4_ld, done;
`ifdef REG_XFER_CHK_EN
  logic       err;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       op;
    logic [1:0] src;
    logic [1:0] dst;
    logic [3:0] data;
    logic [3:0] sw_prev;
  } txn_t;

  txn_t       sb[$];
  logic [3:0] model_sw = 4'h0;

  always #5 clk = ~clk;

  reg_xfer_seq #(
    .SETUP_CYC  (SETUP),
    .STROBE_CYC (STROBE),
    .HOLD_CYC   (HOLD)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_data  (cmd_data),
    .sw_data   (sw_data),
    .bus_sel   (bus_sel),
    .in_ld_n   (in_ld_n),
    .u2_ld_n   (u2_ld_n),
    .u3_ld_n   (u3_ld_n),
    .u4_ld     (u4_ld),
    .done      (done)
`ifdef REG_XFER_CHK_EN
    ,
    .err       (err)
`endif
  );

  function automatic int fin_of(input txn_t t);
    return (t.op == 1'b0) ? 2 * PH + 1 : PH + 1;
  endfunction

  // Expected {sw_data, bus_sel, in_ld_n, u2_ld_n, u3_ld_n, u4_ld, done, cmd_ready} at cycle k.
  function automatic logic [11:0] exp_out(input txn_t t, input int k);
    int         dstart, fin;
    logic [3:0] sw;
    logic [1:0] bs;
    logic       in_n, u2n, u3n, u4, dn, rdy;
    fin    = fin_of(t);
    dstart = (t.op == 1'b0) ? PH : 0;
    sw     = (t.op == 1'b0) ? t.data : t.sw_prev;
    bs     = (t.op == 1'b0) ? 2'b00 : t.src;
    in_n = 1'b1; u2n = 1'b1; u3n = 1'b1; u4 = 1'b0;
    if (t.op == 1'b0 && k >= SETUP + 1 && k <= SETUP + STROBE) in_n = 1'b0;
    if (k >= dstart + SETUP + 1 && k <= dstart + SETUP + STROBE) begin
      case (t.dst)
        2'b01:   u2n = 1'b0;
        2'b10:   u3n = 1'b0;
        2'b11:   u4  = 1'b1;
        default: ;
      endcase
    end
    dn  = (k == fin);
    rdy = (k > fin);
    return {sw, bs, in_n, u2n, u3n, u4, dn, rdy};
  endfunction

  // Issues one command and checks every output for ncyc cycles after acceptance.
  task automatic run_txn(input logic op, input logic [1:0] src, input logic [1:0] dst,
                         input logic [3:0] data, input int ncyc, input bit keep_valid);
    txn_t        cur;
    logic [11:0] exp_v, act_v;
    bit          seen;
    int          fin;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_before_cmd got=%b want=1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_data = data;
    cur = '{op, src, dst, data, model_sw};
    sb.push_back(cur);
    if (op == 1'b0) model_sw = data;
    fin  = fin_of(cur);
    seen = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (keep_valid) begin
          cmd_op = ~op; cmd_src = ~src; cmd_dst = ~dst; cmd_data = ~data;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (keep_valid && k == fin) cmd_valid = 1'b0;
      act_v = {sw_data, bus_sel, in_ld_n, u2_ld_n, u3_ld_n, u4_ld, done, cmd_ready};
      exp_v = exp_out(cur, k);
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL trace op=%b cyc=%0d got=%b want=%b", op, k, act_v, exp_v);
      end
      if (done === 1'b1 && sb.size() > 0) begin
        checks++;
        if (k != fin_of(sb[0])) begin
          failures++;
          $display("FAIL done_cycle got=%0d want=%0d", k, fin_of(sb[0]));
        end
        void'(sb.pop_front());
        seen = 1'b1;
      end
    end
    if (!seen && sb.size() > 0) begin
      if (fin <= ncyc) begin
        checks++;
        failures++;
        $display("FAIL done_missing got=none want=cyc%0d", fin);
      end
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset();
    logic [11:0] act_v;
    resetn = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      act_v = {sw_data, bus_sel, in_ld_n, u2_ld_n, u3_ld_n, u4_ld, done, cmd_ready};
      checks++;
      if (act_v !== 12'b0000_00_1110_0_0) begin
        failures++;
        $display("FAIL reset_values cyc=%0d got=%b want=%b", i, act_v, 12'b0000_00_1110_0_0);
      end
    end
    resetn = 1'b1;
    @(negedge clk);
    act_v = {sw_data, bus_sel, in_ld_n, u2_ld_n, u3_ld_n, u4_ld, done, cmd_ready};
    checks++;
    if (act_v !== 12'b0000_00_1110_0_1) begin
      failures++;
      $display("FAIL reset_release got=%b want=%b", act_v, 12'b0000_00_1110_0_1);
    end
    model_sw = 4'h0;
  endtask

  task automatic test_load();
    run_txn(1'b0, 2'b00, 2'b01, 4'b1010, 2 * PH + 2, 1'b0);
  endtask

  task automatic test_move();
    run_txn(1'b1, 2'b01, 2'b11, 4'b0000, PH + 2, 1'b0);
  endtask

  task automatic test_load_zero();
    run_txn(1'b0, 2'b11, 2'b00, 4'b0000, 2 * PH + 2, 1'b0);
  endtask

  task automatic test_move_u3_nodst();
    run_txn(1'b1, 2'b00, 2'b10, 4'b0110, PH + 2, 1'b0);
    run_txn(1'b1, 2'b11, 2'b00, 4'b0001, PH + 2, 1'b0);
  endtask

  task automatic test_busy_ignored();
    run_txn(1'b1, 2'b10, 2'b11, 4'b1111, PH + 2, 1'b1);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL busy_queue got=%0d want=0", sb.size());
    end
  endtask

  task automatic test_same_reg();
`ifdef REG_XFER_CHK_EN
    logic [5:0] act_v, exp_v;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_src = 2'b10; cmd_dst = 2'b10; cmd_data = 4'h0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      act_v = {err, in_ld_n, u2_ld_n, u3_ld_n, u4_ld, cmd_ready};
      exp_v = {(k == 1), 4'b1110, (k >= 2)};
      checks++;
      if (act_v !== exp_v || done !== 1'b0) begin
        failures++;
        $display("FAIL same_reg_reject cyc=%0d got=%b done=%b want=%b done=0", k, act_v, done, exp_v);
      end
    end
`else
    run_txn(1'b1, 2'b10, 2'b10, 4'h0, PH + 2, 1'b0);
`endif
  endtask

  task automatic test_reset_mid_strobe();
    run_txn(1'b1, 2'b10, 2'b01, 4'h0, SETUP + 5, 1'b1);
    resetn = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({u2_ld_n, done, cmd_ready, in_ld_n, u3_ld_n, u4_ld} !== 6'b100110) begin
      failures++;
      $display("FAIL reset_mid_strobe got=%b want=100110",
               {u2_ld_n, done, cmd_ready, in_ld_n, u3_ld_n, u4_ld});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || u2_ld_n !== 1'b1) begin
        failures++;
        $display("FAIL reset_no_done cyc=%0d got=%b%b want=01", i, done, u2_ld_n);
      end
    end
    resetn = 1'b1;
    model_sw = 4'h0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_release got=%b%b want=10", cmd_ready, done);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_move();
    test_load_zero();
    test_move_u3_nodst();
    test_busy_ignored();
    test_same_reg();
    test_reset_mid_strobe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
